i2c_init_seq: RTL and testbench
===============================

# i2c_init_seq

Upstream command sequencer for `i2c_master`. Steps through a fixed table of data bytes, issuing one single-byte I2C write per entry to a fixed 7-bit slave address. Drives the master's `start`/`ready` handshake and inserts a programmable idle gap between writes, so the tracking camera can be configured after power-up without CPU involvement. Reports completion, and a handshake timeout as an error.

## Interface
- `SLAVE_ADDR`, 7'h58, 7-bit I2C address driven on `i2c_addr` for every write.
- `NUM_CMDS`, 8, number of table entries sent (1..8).
- `GAP_CYCLES`, 16, idle clocks between the end of one write and the next `start` (0..65535).
- `ACCEPT_TIMEOUT`, 255, maximum clocks `i2c_start` may be held high without the master dropping `i2c_ready` (1..65535).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `go`  in  1  request to run the sequence; sampled on the rising edge of `clk`.
- `i2c_ready`  in  1  from `i2c_master` `ready`; high = idle.
- `i2c_start`  out  1  to `i2c_master` `start`.
- `i2c_addr`  out  7  to `i2c_master` `addr`; constant `SLAVE_ADDR`.
- `i2c_data`  out  8  to `i2c_master` `data`; current table byte.
- `busy`  out  1  sequence in progress.
- `done`  out  1  sequence finished; stays high until the next run or reset.
- `error`  out  1  the finished run was aborted by timeout; only meaningful while `done`=1.
- `index`  out  3  current table entry.

## Operation
- Table, fixed in the block, entries 0..7: 0x30, 0x01, 0x30, 0x08, 0x06, 0x90, 0x08, 0xC0.
  - Entries at or beyond `NUM_CMDS` are never sent.
- Reset values, applied asynchronously while `reset`=0:
  - `i2c_start`=0, `i2c_data`=0x00, `busy`=0, `done`=0, `error`=0, `index`=0.
  - Internal counters 0; state IDLE.
  - `i2c_addr`=`SLAVE_ADDR` at all times.
- States:
  - IDLE: `busy`=0. On `go`=1: `index`←0, `done`←0, `error`←0, `busy`←1, go to LOAD.
  - LOAD: `i2c_data`←table[`index`]. Stay until `i2c_ready`=1. Then `i2c_start`←1, clear the timeout counter, go to ACCEPT.
  - ACCEPT: hold `i2c_start`=1 and `i2c_data` stable.
    - If `i2c_ready`=0: `i2c_start`←0, go to XFER.
    - Else increment the timeout counter. When it reaches `ACCEPT_TIMEOUT`: `i2c_start`←0, `error`←1, `done`←1, `busy`←0, go to DONE.
  - XFER: keep `i2c_data` stable. Wait for `i2c_ready`=1.
    - If `index`=`NUM_CMDS`-1: `done`←1, `busy`←0, go to DONE.
    - Else `index`←`index`+1, load the gap counter with `GAP_CYCLES`, go to GAP.
    - If `GAP_CYCLES`=0, go directly to LOAD instead of GAP.
  - GAP: decrement the counter each clock. When it reaches 1, go to LOAD.
  - DONE: `done`=1. On `go`=1, behave exactly as IDLE on `go` (restart from entry 0, clear `done`/`error`).
- `go` is ignored in LOAD, ACCEPT, XFER and GAP.
- `i2c_data` changes only on entry to LOAD.
- The block never asserts `i2c_start` while `i2c_ready`=0.

## Timing
- All outputs are registered.
- `go` sampled at edge N:
  - `busy`=1 and state LOAD after edge N.
  - `i2c_data` valid after edge N+1.
  - `i2c_start` high after edge N+2, provided `i2c_ready`=1.
- `i2c_start` falls one clock after the edge at which `i2c_ready`=0 is sampled. Master-side overlap is therefore exactly 1 cycle.
- Gap: the `i2c_ready` rise is sampled at edge M. The next `i2c_start` rises after edge M+`GAP_CYCLES`+2.
- Reset mid-transfer: `i2c_start` drops immediately (asynchronous). The master must be reset by the same signal.

## Test plan
- Full run, `NUM_CMDS`=8, `GAP_CYCLES`=4, behavioural master (ready drops 1 clk after start, returns 20 clks later) → eight writes, addr 0x58, data 0x30,0x01,0x30,0x08,0x06,0x90,0x08,0xC0 in order; then `done`=1, `error`=0, `busy`=0.
- Gap check, `GAP_CYCLES`=0 and `GAP_CYCLES`=16 → measured ready-rise to next start-rise is 2 and 18 clocks respectively.
- Timeout, master holds `i2c_ready`=1 forever, `ACCEPT_TIMEOUT`=10 → `i2c_start` high for exactly 10 clocks, then `done`=1, `error`=1, `index`=0.
- `go` pulsed during entry 3 XFER → ignored, sequence unaffected. `go` in DONE → restart from entry 0 with `done` cleared 1 clock later.
- `reset` low during ACCEPT of entry 2 → all outputs at reset values in the same cycle. After release, the block stays in IDLE until `go`.
- `NUM_CMDS`=1 → a single write of 0x30, then `done`=1.

Source files
------------

// File: rtl/i2c_init_seq.sv
// i2c_init_seq: walks a fixed table of bytes, issuing one single-byte write per entry
// to i2c_master via its start/ready handshake, with an idle gap and an accept timeout.
module i2c_init_seq #(
   parameter logic [6:0]  SLAVE_ADDR     = 7'h58,
   parameter int unsigned NUM_CMDS       = 8,
   parameter int unsigned GAP_CYCLES     = 16,
   parameter int unsigned ACCEPT_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       go,
   input  logic       i2c_ready,
   output logic       i2c_start,
   output logic [6:0] i2c_addr,
   output logic [7:0] i2c_data,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [2:0] index
);

   localparam int unsigned        CNT_W    = 16;
   localparam logic [2:0]         LAST_IDX = 3'(NUM_CMDS - 1);
   localparam logic [CNT_W-1:0]   GAP_LOAD = CNT_W'(GAP_CYCLES);
   localparam logic [CNT_W-1:0]   TO_LAST  = CNT_W'(ACCEPT_TIMEOUT - 1);
   localparam logic               NO_GAP   = (GAP_CYCLES == 0);

   // LOAD latches the byte; ARM waits for an idle master before raising start.
   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ARM,
      S_ACCEPT,
      S_XFER,
      S_GAP,
      S_DONE
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             start_n, busy_n, done_n, error_n;
   logic [7:0]       data_n;
   logic [2:0]       index_n;

   function automatic logic [7:0] cmd_byte(input logic [2:0] i);
      case (i)
         3'd0:    return 8'h30;
         3'd1:    return 8'h01;
         3'd2:    return 8'h30;
         3'd3:    return 8'h08;
         3'd4:    return 8'h06;
         3'd5:    return 8'h90;
         3'd6:    return 8'h08;
         default: return 8'hC0;
      endcase
   endfunction

   assign i2c_addr = SLAVE_ADDR;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         i2c_start <= 1'b0;
         i2c_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         index     <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         i2c_start <= start_n;
         i2c_data  <= data_n;
         busy      <= busy_n;
         done      <= done_n;
         error     <= error_n;
         index     <= index_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      start_n = i2c_start;
      data_n  = i2c_data;
      busy_n  = busy;
      done_n  = done;
      error_n = error;
      index_n = index;

      case (state)
         S_IDLE, S_DONE: begin
            if (go) begin
               index_n = '0;
               done_n  = 1'b0;
               error_n = 1'b0;
               busy_n  = 1'b1;
               state_n = S_LOAD;
            end
         end
         S_LOAD: begin
            data_n  = cmd_byte(index);
            state_n = S_ARM;
         end
         S_ARM: begin
            if (i2c_ready) begin
               start_n = 1'b1;
               cnt_n   = '0;
               state_n = S_ACCEPT;
            end
         end
         S_ACCEPT: begin
            if (!i2c_ready) begin
               start_n = 1'b0;
               state_n = S_XFER;
            end else if (cnt == TO_LAST) begin
               start_n = 1'b0;
               error_n = 1'b1;
               done_n  = 1'b1;
               busy_n  = 1'b0;
               state_n = S_DONE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_XFER: begin
            if (i2c_ready) begin
               if (index == LAST_IDX) begin
                  done_n  = 1'b1;
                  busy_n  = 1'b0;
                  state_n = S_DONE;
               end else begin
                  index_n = index + 1'b1;
                  cnt_n   = GAP_LOAD;
                  state_n = NO_GAP ? S_LOAD : S_GAP;
               end
            end
         end
         S_GAP: begin
            if (cnt <= CNT_W'(1)) begin
               state_n = S_LOAD;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_i2c_init_seq.sv
// Bench for i2c_init_seq: four parameterisations driven by randomised master models,
// with a scoreboard of expected writes checked by an independent monitor.
module tb_i2c_init_seq;

   localparam int NI = 4;

   function automatic int cfg_num(input int k);
      return (k == 3) ? 1 : 8;
   endfunction
   function automatic int cfg_gap(input int k);
      case (k)
         0:       return 4;
         1:       return 0;
         default: return 16;
      endcase
   endfunction
   function automatic int cfg_to(input int k);
      return (k == 0) ? 10 : 255;
   endfunction

   typedef struct {
      int         inst;
      logic [7:0] data;
      bit         first;
   } exp_t;

   logic [7:0] tab [8] = '{8'h30, 8'h01, 8'h30, 8'h08, 8'h06, 8'h90, 8'h08, 8'hC0};

   logic       clk = 1'b0;
   logic       reset;
   logic       go      [NI];
   logic       hold    [NI];
   logic       ready   [NI];
   logic       start   [NI];
   logic [6:0] addr    [NI];
   logic [7:0] data    [NI];
   logic       busy_o  [NI];
   logic       done_o  [NI];
   logic       err_o   [NI];
   logic [2:0] idx_o   [NI];

   exp_t exp_q [$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      int unsigned busy_cnt;

      i2c_init_seq #(
         .SLAVE_ADDR    (7'h58),
         .NUM_CMDS      (cfg_num(gi)),
         .GAP_CYCLES    (cfg_gap(gi)),
         .ACCEPT_TIMEOUT(cfg_to(gi))
      ) u_dut (
         .clk      (clk),
         .reset    (reset),
         .go       (go[gi]),
         .i2c_ready(ready[gi]),
         .i2c_start(start[gi]),
         .i2c_addr (addr[gi]),
         .i2c_data (data[gi]),
         .busy     (busy_o[gi]),
         .done     (done_o[gi]),
         .error    (err_o[gi]),
         .index    (idx_o[gi])
      );

      // Master model: accepts start while idle, then stays busy a random number of clocks.
      always @(posedge clk or negedge reset) begin
         if (!reset) begin
            ready[gi] <= 1'b1;
            busy_cnt  <= 0;
         end else if (hold[gi]) begin
            ready[gi] <= 1'b1;
         end else if (ready[gi] && start[gi]) begin
            ready[gi] <= 1'b0;
            busy_cnt  <= $urandom_range(2, 20);
         end else if (!ready[gi]) begin
            if (busy_cnt <= 1) ready[gi] <= 1'b1;
            else busy_cnt <= busy_cnt - 1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_run(input int k, input int n);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         e.inst  = k;
         e.data  = tab[i];
         e.first = (i == 0);
         exp_q.push_back(e);
      end
   endtask

   task automatic pulse_go(input int k);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      go[k] = 1'b1;
      @(negedge clk);
      go[k] = 1'b0;
      check("busy_after_go", 32'(busy_o[k]), 32'd1);
      check("done_cleared", 32'(done_o[k]), 32'd0);
      check("error_cleared", 32'(err_o[k]), 32'd0);
      check("index_zero", 32'(idx_o[k]), 32'd0);
   endtask

   task automatic wait_done(input int k, input int budget);
      int c = 0;
      while (!done_o[k] && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("done_within_budget", (c < budget) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic check_end(input int k, input logic err_exp, input logic [2:0] idx_exp);
      check("done_final", 32'(done_o[k]), 32'd1);
      check("busy_final", 32'(busy_o[k]), 32'd0);
      check("error_final", 32'(err_o[k]), 32'(err_exp));
      check("index_final", 32'(idx_o[k]), 32'(idx_exp));
      check("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: every start rise is one write presentation, matched against the scoreboard.
   initial begin
      logic       prev_start [NI];
      logic       prev_ready [NI];
      logic [7:0] prev_data  [NI];
      int         rise_cyc   [NI];
      int         hi_len     [NI];
      exp_t       e;
      for (int k = 0; k < NI; k++) begin
         prev_start[k] = 1'b0;
         prev_ready[k] = 1'b1;
         prev_data[k]  = '0;
         rise_cyc[k]   = 0;
         hi_len[k]     = 0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < NI; k++) begin
            if (start[k] && !prev_start[k]) begin
               check("start_needs_ready", 32'(ready[k]), 32'd1);
               check("addr", 32'(addr[k]), 32'h58);
               if (exp_q.size() == 0) begin
                  check("unexpected_start", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("write_inst", 32'(k), 32'(e.inst));
                  check("write_data", 32'(data[k]), 32'(e.data));
                  if (!e.first)
                     check("gap_clocks", 32'(cyc - rise_cyc[k] - 1), 32'(cfg_gap(k) + 2));
               end
               hi_len[k] = 0;
            end
            if (start[k] && prev_start[k])
               check("data_stable", 32'(data[k]), 32'(prev_data[k]));
            if (start[k]) hi_len[k]++;
            if (!start[k] && prev_start[k] && hold[k])
               check("start_high_len", 32'(hi_len[k]), 32'(cfg_to(k)));
            if (ready[k] && !prev_ready[k]) rise_cyc[k] = cyc;
            prev_start[k] = start[k];
            prev_ready[k] = ready[k];
            prev_data[k]  = data[k];
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, %0d compared / %0d mismatched", n_cmp, n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      reset = 1'b0;
      for (int k = 0; k < NI; k++) begin
         go[k]   = 1'b0;
         hold[k] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         check("rst_start", 32'(start[k]), 32'd0);
         check("rst_data", 32'(data[k]), 32'd0);
         check("rst_busy", 32'(busy_o[k]), 32'd0);
         check("rst_done", 32'(done_o[k]), 32'd0);
         check("rst_error", 32'(err_o[k]), 32'd0);
         check("rst_index", 32'(idx_o[k]), 32'd0);
         check("rst_addr", 32'(addr[k]), 32'h58);
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Full runs on every parameterisation (gap 4, 0, 16 and a single entry).
      for (int k = 0; k < NI; k++) begin
         push_run(k, cfg_num(k));
         pulse_go(k);
         wait_done(k, 2000);
         check_end(k, 1'b0, 3'(cfg_num(k) - 1));
      end

      // Restart from DONE, with go pulsed during the transfer of entry 3.
      push_run(0, 8);
      pulse_go(0);
      c = 0;
      while (!(idx_o[0] == 3'd3 && !start[0] && !ready[0] && busy_o[0]) && c < 1000) begin
         @(negedge clk);
         c++;
      end
      check("reach_entry3_xfer", (c < 1000) ? 32'd1 : 32'd0, 32'd1);
      go[0] = 1'b1;
      @(negedge clk);
      go[0] = 1'b0;
      wait_done(0, 2000);
      check_end(0, 1'b0, 3'd7);

      // Master never accepts: start held for the timeout, then an error completion.
      hold[0] = 1'b1;
      push_run(0, 1);
      pulse_go(0);
      wait_done(0, 200);
      check_end(0, 1'b1, 3'd0);
      @(negedge clk);
      hold[0] = 1'b0;

      // Reset asserted while entry 2 waits for acceptance.
      push_run(0, 8);
      pulse_go(0);
      c = 0;
      while (!(idx_o[0] == 3'd2 && start[0]) && c < 1000) begin
         @(negedge clk);
         c++;
      end
      check("reach_entry2_accept", (c < 1000) ? 32'd1 : 32'd0, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_start", 32'(start[0]), 32'd0);
      check("mid_rst_data", 32'(data[0]), 32'd0);
      check("mid_rst_busy", 32'(busy_o[0]), 32'd0);
      check("mid_rst_done", 32'(done_o[0]), 32'd0);
      check("mid_rst_error", 32'(err_o[0]), 32'd0);
      check("mid_rst_index", 32'(idx_o[0]), 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      #2;
      reset = 1'b1;
      repeat (40) @(negedge clk);
      check("post_rst_busy", 32'(busy_o[0]), 32'd0);
      check("post_rst_done", 32'(done_o[0]), 32'd0);
      check("post_rst_start", 32'(start[0]), 32'd0);

      // Sequence still runs normally after the reset.
      push_run(0, 8);
      pulse_go(0);
      wait_done(0, 2000);
      check_end(0, 1'b0, 3'd7);

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
